ring_seq_checker: RTL and testbench



---
 rtl/ring_pkg.sv | 25 ++
 rtl/ring_seq_checker_if.sv | 27 ++
 rtl/ring_onehot_enc.sv | 30 +++
 rtl/ring_seq_checker.sv | 130 +++++++++++++
 tb/tb_ring_seq_checker.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-bus sequence checker.
package ring_pkg;

  localparam int MaxWidth = 64;

  typedef enum logic [1:0] {Unlocked, Acquire, Locked} ring_state_e;
  typedef enum logic [1:0] {Zero, Onehot, Multi} ring_class_e;

  // Rotate the low 'width' bits of vec by one place; dir=0 moves bit i to bit i+1.
  function automatic logic [MaxWidth-1:0] ring_rotate(input logic [MaxWidth-1:0] vec,
                                                       input int width, input logic dir);
    logic [MaxWidth-1:0] res;
    int dst;
    res = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < width) begin
        if (dir) dst = (i == 0) ? width - 1 : i - 1;
        else     dst = (i == width - 1) ? 0 : i + 1;
        res[dst[5:0]] = vec[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_seq_checker_if.sv
// Ring bus sample input plus checker status outputs.
interface ring_seq_checker_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  logic [WIDTH-1:0]     ring_in;
  logic                 ring_valid;
  logic [IdxW-1:0]      index;
  logic                 index_valid;
  logic                 locked;
  logic                 onehot_err;
  logic                 seq_err;
  logic                 wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output ring_in, ring_valid,
    input  index, index_valid, locked, onehot_err, seq_err, wrap_pulse, err_count
  );

  modport slave (
    input  ring_in, ring_valid,
    output index, index_valid, locked, onehot_err, seq_err, wrap_pulse, err_count
  );
endinterface

// File: rtl/ring_onehot_enc.sv
// Classifies a ring sample as zero / one-hot / multi-hot and encodes the hot position.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IdxW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output ring_class_e      cls,
  output logic [IdxW-1:0]  idx
);

  logic any_set;
  logic multi_set;

  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        multi_set = multi_set | any_set;
        any_set   = 1'b1;
        idx       = IdxW'(i);
      end
    end
    cls = multi_set ? Multi : (any_set ? Onehot : Zero);
  end

endmodule

// File: rtl/ring_seq_checker.sv
// Checks that a ring bus carries one-hot codes advancing one place per qualified sample.
module ring_seq_checker
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter bit          DIR        = 1'b0,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input logic               clk,
  input logic               clr,
  ring_seq_checker_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(WIDTH);
  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

  ring_state_e          state_q;
  logic [WIDTH-1:0]     prev_q;
  logic [GoodW-1:0]     good_q;
  logic [IdxW-1:0]      index_q;
  logic                 index_valid_q;
  logic                 onehot_err_q;
  logic                 seq_err_q;
  logic                 wrap_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  ring_class_e          cls;
  logic [IdxW-1:0]      enc_idx;
  logic [MaxWidth-1:0]  rot;
  logic [WIDTH-1:0]     exp_vec;
  logic                 match;
  logic                 at_start;
  logic                 err_evt;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IdxW  (IdxW)
  ) u_enc (
    .vec (bus.ring_in),
    .cls (cls),
    .idx (enc_idx)
  );

  assign rot      = ring_rotate(MaxWidth'(prev_q), WIDTH, DIR);
  assign exp_vec  = rot[WIDTH-1:0];
  assign match    = (cls == Onehot) && (bus.ring_in == exp_vec);
  // A matched advance landing on the start position is the end-to-start wrap.
  assign at_start = DIR ? bus.ring_in[WIDTH-1] : bus.ring_in[0];
  assign err_evt  = bus.ring_valid &&
                    ((cls == Multi) || (state_q == Locked && cls == Onehot && !match));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= Unlocked;
      prev_q        <= '0;
      good_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      onehot_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      wrap_q        <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
      if (bus.ring_valid) begin
        if (cls == Onehot) begin
          index_q       <= enc_idx;
          index_valid_q <= 1'b1;
          prev_q        <= bus.ring_in;
        end else begin
          index_valid_q <= 1'b0;
        end
        if (err_evt && err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);

        unique case (state_q)
          Unlocked: begin
            if (cls == Onehot) begin
              good_q  <= '0;
              state_q <= Acquire;
            end else if (cls == Multi) begin
              onehot_err_q <= 1'b1;
            end
          end
          Acquire: begin
            if (cls == Onehot) begin
              if (!match) begin
                good_q <= '0;
              end else if (good_q == GoodW'(LOCK_COUNT - 1)) begin
                good_q  <= '0;
                state_q <= Locked;
              end else begin
                good_q <= good_q + GoodW'(1);
              end
            end else begin
              onehot_err_q <= (cls == Multi);
              state_q      <= Unlocked;
            end
          end
          Locked: begin
            if (cls == Onehot) begin
              if (match) begin
                wrap_q <= at_start;
              end else begin
                seq_err_q <= 1'b1;
                good_q    <= '0;
                state_q   <= Acquire;
              end
            end else begin
              onehot_err_q <= (cls == Multi);
              state_q      <= Unlocked;
            end
          end
          default: state_q <= Unlocked;
        endcase
      end
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.locked      = (state_q == Locked);
  assign bus.onehot_err  = onehot_err_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.wrap_pulse  = wrap_q;
  assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// Directed and random checks of ring_seq_checker against a position-level reference model.
module tb_ring_seq_checker;

  localparam int W = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  ring_seq_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) bus ();
  ring_seq_checker_if #(.WIDTH(W), .ERR_CNT_W(2)) bus2 ();

  ring_seq_checker #(.WIDTH(W), .LOCK_COUNT(L), .DIR(1'b0), .ERR_CNT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  ring_seq_checker #(.WIDTH(W), .LOCK_COUNT(L), .DIR(1'b0), .ERR_CNT_W(2)) dut2 (
    .clk (clk),
    .clr (clr),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: hot positions as integers, a run length and a lock flag.
  int m_index, m_ref, m_run, m_err, m_err2;
  bit m_iv, m_locked, m_oh, m_seq, m_wrap, m_have_ref;

  task automatic model_reset();
    m_index = 0; m_ref = 0; m_run = 0; m_err = 0; m_err2 = 0;
    m_iv = 0; m_locked = 0; m_oh = 0; m_seq = 0; m_wrap = 0; m_have_ref = 0;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
    if (m_err2 < 3) m_err2++;
  endtask

  task automatic model_step(input logic [W-1:0] s, input bit v);
    int n, pos;
    bit good;
    m_oh = 0; m_seq = 0; m_wrap = 0;
    if (!v) return;
    n = $countones(s);
    pos = 0;
    for (int i = 0; i < W; i++) if (s[i]) pos = i;
    m_iv = (n == 1);
    if (n == 1) m_index = pos;
    if (n == 0) begin
      m_have_ref = 0; m_locked = 0;
    end else if (n > 1) begin
      m_oh = 1; m_have_ref = 0; m_locked = 0; bump_err();
    end else begin
      good = m_have_ref && (pos == (m_ref + 1) % W);
      if (m_locked) begin
        if (good) m_wrap = (pos == 0);
        else begin
          m_seq = 1; m_locked = 0; m_run = 0; bump_err();
        end
      end else if (good) begin
        m_run++;
        if (m_run == L) m_locked = 1;
      end else begin
        m_run = 0;
      end
      m_have_ref = 1; m_ref = pos;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("index", 32'(bus.index), m_index);
    chk("index_valid", 32'(bus.index_valid), 32'(m_iv));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("onehot_err", 32'(bus.onehot_err), 32'(m_oh));
    chk("seq_err", 32'(bus.seq_err), 32'(m_seq));
    chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_wrap));
    chk("err_count", 32'(bus.err_count), m_err);
    chk("err_count_w2", 32'(bus2.err_count), m_err2);
    chk("onehot_err_w2", 32'(bus2.onehot_err), 32'(m_oh));
  endtask

  task automatic apply(input logic [W-1:0] s, input bit v);
    @(negedge clk);
    bus.ring_in = s;  bus.ring_valid = v;
    bus2.ring_in = s; bus2.ring_valid = v;
    @(posedge clk);
    model_step(s, v);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] s;
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] lock_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    bus.ring_in = '0;  bus.ring_valid = 1'b0;
    bus2.ring_in = '0; bus2.ring_valid = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    clr = 1'b0;

    apply(4'b0001, 1'b1);
    chk("first_iv", 32'(bus.index_valid), 1);
    chk("first_index", 32'(bus.index), 0);

    // Lock and wrap.
    for (int i = 0; i < 5; i++) begin
      apply(lock_seq[i], 1'b1);
      chk("lock_index", 32'(bus.index), exp_idx[i]);
      chk("lock_state", 32'(bus.locked), (i >= 2) ? 1 : 0);
      chk("lock_wrap", 32'(bus.wrap_pulse), (i == 4) ? 1 : 0);
    end
    apply(4'b0010, 1'b1);
    chk("wrap_one_cycle", 32'(bus.wrap_pulse), 0);

    // Sequence error while locked at 0010.
    apply(4'b1000, 1'b1);
    chk("seq_err_pulse", 32'(bus.seq_err), 1);
    chk("seq_err_count", 32'(bus.err_count), 1);
    chk("seq_err_unlock", 32'(bus.locked), 0);
    apply(4'b0001, 1'b1);
    chk("relock_pending", 32'(bus.locked), 0);
    apply(4'b0010, 1'b1);
    chk("relock", 32'(bus.locked), 1);

    // Multi-hot while locked.
    apply(4'b0110, 1'b1);
    chk("multi_oh", 32'(bus.onehot_err), 1);
    chk("multi_seq", 32'(bus.seq_err), 0);
    chk("multi_iv", 32'(bus.index_valid), 0);
    chk("multi_index_hold", 32'(bus.index), 1);
    chk("multi_count", 32'(bus.err_count), 2);
    chk("multi_unlock", 32'(bus.locked), 0);

    // Idle gating, then legal zero.
    apply(4'b0100, 1'b1);
    apply(4'b1000, 1'b1);
    apply(4'b0001, 1'b1);
    chk("relock2", 32'(bus.locked), 1);
    for (int i = 0; i < 5; i++) begin
      apply(4'($urandom), 1'b0);
      chk("idle_locked", 32'(bus.locked), 1);
      chk("idle_index", 32'(bus.index), 0);
    end
    apply(4'b0000, 1'b1);
    chk("zero_unlock", 32'(bus.locked), 0);
    chk("zero_no_err", 32'(bus.onehot_err | bus.seq_err), 0);
    chk("zero_count", 32'(bus.err_count), 2);

    // Mid-cycle asynchronous clear.
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("clr_count", 32'(bus.err_count), 0);
    @(negedge clk);
    clr = 1'b0;
    apply(4'b0001, 1'b1);
    chk("post_clr_iv", 32'(bus.index_valid), 1);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      apply(4'b0111, 1'b1);
      chk("sat_count", 32'(bus2.err_count), exp_sat[i]);
      chk("sat_pulse", 32'(bus2.onehot_err), 1);
    end

    // Random traffic biased toward correct advances.
    for (int k = 0; k < 400; k++) begin
      int c;
      c = int'($urandom_range(99));
      if (c < 60 && m_have_ref) s = 4'(1 << ((m_ref + 1) % W));
      else if (c < 75)          s = 4'(1 << $urandom_range(W - 1));
      else if (c < 83)          s = '0;
      else                      s = 4'($urandom);
      apply(s, $urandom_range(99) < 85);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
